// File: rtl/csi2tx_ldl_pkt_scheduler_if.sv
// Packet-source and LDL-facing signals of the LDL packet scheduler.
// master = scheduler side, slave = packet sources plus LDL/HS-exit logic.
interface csi2tx_ldl_pkt_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0] pkt_req;
    logic [NUM_REQ-1:0] pkt_short;
    logic [NUM_REQ-1:0] pkt_grant;
    logic [2:0]         grant_id;
    logic               enable_hs_transmission;
    logic               short_packet;
    logic [3:0]         lane_en;
    logic               tx_done;
    logic               hs_exit_cnt_expired;

    modport master (
        input  pkt_req, pkt_short, tx_done, hs_exit_cnt_expired,
        output pkt_grant, grant_id, enable_hs_transmission, short_packet, lane_en
    );

    modport slave (
        output pkt_req, pkt_short, tx_done, hs_exit_cnt_expired,
        input  pkt_grant, grant_id, enable_hs_transmission, short_packet, lane_en
    );
endinterface

// File: rtl/csi2tx_ldl_pkt_scheduler.sv
// Round-robin packet scheduler sharing the CSI-2 TX lane distribution layer.
// Optional WAIT_DONE watchdog enabled by defining CSI2TX_LDL_SCHED_TIMEOUT_EN.
module csi2tx_ldl_pkt_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       txbyteclkhs,
    input  logic       txbyteclkhs_rst,
    input  logic       tinit_start,
    input  logic       forcetxstopmode,
    input  logic [1:0] lane_cfg,
    input  logic       lane_cfg_wr,
    output logic [1:0] active_lane_cfg,
    output logic       busy,
    output logic       timeout_err,
    csi2tx_ldl_pkt_scheduler_if.master ldl
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned GAP_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_WAIT_DONE,
        ST_WAIT_EXIT,
        ST_GAP
    } state_t;

    state_t             state, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [2:0]         gid_q, gid_d;
    logic               short_q, short_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic [3:0]         lane_q, lane_d;
    logic [1:0]         active_q, active_d;
    logic [1:0]         pend_q, pend_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               err_q, err_d;
    logic               found;
    logic [PTR_W-1:0]   win;

`ifdef CSI2TX_LDL_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] tcnt_q, tcnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // Round-robin pick: first request at or after the pointer, wrapping.
    always_comb begin : arb_pick
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            idx = int'(rr_q) + i;
            if (idx >= int'(NUM_REQ)) begin
                idx = idx - int'(NUM_REQ);
            end
            if (!found && ldl.pkt_req[PTR_W'(idx)]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    // Next-state and registered-output values.
    always_comb begin : next_state
        state_d  = state;
        grant_d  = grant_q;
        gid_d    = gid_q;
        short_d  = short_q;
        rr_d     = rr_q;
        gap_d    = gap_q;
        err_d    = err_q;
        active_d = active_q;
        pend_d   = lane_cfg_wr ? lane_cfg : pend_q;
`ifdef CSI2TX_LDL_SCHED_TIMEOUT_EN
        tcnt_d   = tcnt_q;
`endif

        case (state)
            ST_IDLE: begin
                // Same-cycle write is forwarded so a packet never starts on a stale count.
                active_d = pend_d;
                if (|ldl.pkt_req) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (found) begin
                    state_d = ST_WAIT_DONE;
                    grant_d = NUM_REQ'(1) << win;
                    gid_d   = 3'(win);
                    short_d = ldl.pkt_short[win];
                    rr_d    = (int'(win) == int'(NUM_REQ) - 1) ? '0 : win + 1'b1;
`ifdef CSI2TX_LDL_SCHED_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (ldl.tx_done) begin
                    state_d = ST_WAIT_EXIT;
`ifdef CSI2TX_LDL_SCHED_TIMEOUT_EN
                end else if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d  = tcnt_q + 1'b1;
`endif
                end
            end
            ST_WAIT_EXIT: begin
                if (ldl.hs_exit_cnt_expired) begin
                    grant_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = GAP_W'(GAP_CYCLES - 1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // PHY not initialised or stop-mode abort: drop the packet, keep configuration.
        if (!tinit_start || forcetxstopmode) begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            gap_d    = '0;
            active_d = active_q;
        end

        en_d   = (state_d == ST_WAIT_DONE);
        busy_d = (state_d != ST_IDLE);
        lane_d = 4'b0000;
        if (tinit_start) begin
            case (active_d)
                2'b00:   lane_d = 4'b0001;
                2'b01:   lane_d = 4'b0010;
                2'b10:   lane_d = 4'b0100;
                default: lane_d = 4'b1000;
            endcase
        end
    end

    // State register.
    always_ff @(posedge txbyteclkhs) begin
        if (txbyteclkhs_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Output and configuration registers.
    always_ff @(posedge txbyteclkhs) begin
        if (txbyteclkhs_rst) begin
            grant_q  <= '0;
            gid_q    <= '0;
            short_q  <= 1'b0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            lane_q   <= '0;
            active_q <= '0;
            pend_q   <= '0;
            rr_q     <= '0;
            gap_q    <= '0;
            err_q    <= 1'b0;
`ifdef CSI2TX_LDL_SCHED_TIMEOUT_EN
            tcnt_q   <= '0;
`endif
        end else begin
            grant_q  <= grant_d;
            gid_q    <= gid_d;
            short_q  <= short_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            lane_q   <= lane_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            rr_q     <= rr_d;
            gap_q    <= gap_d;
            err_q    <= err_d;
`ifdef CSI2TX_LDL_SCHED_TIMEOUT_EN
            tcnt_q   <= tcnt_d;
`endif
        end
    end

    assign ldl.pkt_grant              = grant_q;
    assign ldl.grant_id               = gid_q;
    assign ldl.short_packet           = short_q;
    assign ldl.enable_hs_transmission = en_q;
    assign ldl.lane_en                = lane_q;
    assign active_lane_cfg            = active_q;
    assign busy                       = busy_q;
    assign timeout_err                = err_q;

endmodule

// File: doc/csi2tx_ldl_pkt_scheduler.md
Name: csi2tx_ldl_pkt_scheduler

Overview:
- Sequences the high-speed lane distribution layer (LDL) and shares it between NUM_REQ packet sources, such as virtual-channel packet builders.
- Arbitrates round-robin, one packet at a time. It drives the LDL's enable/short-packet/lane-mode inputs, then tracks the LDL through tx_done, stop state and HS-exit before issuing the next grant.
- Owns the active lane-count configuration. A new lane count is applied only while the LDL is idle.

Parameters:
NUM_REQ, 4, number of packet requesters (2..8)
GAP_CYCLES, 4, idle txbyteclkhs cycles inserted after HS-exit before the next grant (0..255)
TIMEOUT_CYCLES, 4096, watchdog limit for WAIT_DONE (used only with the optional feature)

Ports:
txbyteclkhs  in  1  byte clock; the only clock in the block
txbyteclkhs_rst  in  1  reset, synchronous, active-high
tinit_start  in  1  0 = PHY init not done; holds the block in IDLE
forcetxstopmode  in  1  1 = abort; returns to IDLE
lane_cfg  in  2  requested lane count: 00=1, 01=2, 10=4, 11=8
lane_cfg_wr  in  1  one-cycle strobe that captures lane_cfg
pkt_req  in  NUM_REQ  per-source request, level; held until granted
pkt_short  in  NUM_REQ  per-source short-packet flag, valid with pkt_req
pkt_grant  out  NUM_REQ  one-hot grant, held for the whole packet
grant_id  out  3  index of the granted source
enable_hs_transmission  out  1  to LDL
short_packet  out  1  to LDL; latched pkt_short of the granted source
lane_en  out  4  one-hot {eight,four,two,one}_lane_en to the LDLs
active_lane_cfg  out  2  lane count currently applied
tx_done  in  1  from LDL; high while the LDL is in STOP_STATE
hs_exit_cnt_expired  in  1  from the HS-exit counter
busy  out  1  1 in any state other than IDLE
timeout_err  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset (txbyteclkhs_rst=1 at a clock edge) gives:
  - state IDLE
  - pkt_grant=0, grant_id=0, enable_hs_transmission=0, short_packet=0, busy=0, timeout_err=0
  - active_lane_cfg=2'b00, pending config=2'b00, RR pointer=0
  - lane_en=0, because tinit_start is 0 after reset
- Reset priority: reset, then tinit_start==0, then forcetxstopmode==1. The last two force state IDLE, clear pkt_grant, enable_hs_transmission and the gap counter, and leave active_lane_cfg, the pending config and the RR pointer intact.
- lane_cfg_wr captures lane_cfg into the pending register in any state. The latest write wins.
- lane_en = one-hot decode of active_lane_cfg when tinit_start=1, else 0.
- States:
  - IDLE:
    - Copy pending into active_lane_cfg on this cycle.
    - If any pkt_req bit is set, go to ARB.
  - ARB:
    - Pick the first set pkt_req at or after the RR pointer, wrapping modulo NUM_REQ.
    - Register pkt_grant, grant_id, short_packet.
    - Set RR pointer = winner+1, wrapping to 0 at NUM_REQ.
    - Go to WAIT_DONE.
    - If pkt_req drops to 0 in ARB, return to IDLE with no grant.
  - WAIT_DONE:
    - enable_hs_transmission=1.
    - On tx_done=1, drop enable_hs_transmission on the next edge and go to WAIT_EXIT.
  - WAIT_EXIT:
    - enable_hs_transmission=0, grant still held.
    - On hs_exit_cnt_expired=1, clear pkt_grant.
    - Go to GAP, or to IDLE if GAP_CYCLES=0.
  - GAP:
    - Down-counter loaded with GAP_CYCLES-1.
    - Go to IDLE when it reaches 0.
- Latency:
  - Request to pkt_grant: 2 cycles (IDLE→ARB→WAIT_DONE).
  - tx_done to enable_hs_transmission low: 1 cycle.
- pkt_req deasserting mid-packet is ignored; the grant holds until HS-exit.
- tx_done and hs_exit_cnt_expired arriving together in WAIT_DONE: go to WAIT_EXIT only; the expiry is not used.
- lane_cfg_wr while busy takes effect at the next IDLE. A new packet never starts on a stale lane count.
- grant_id width is fixed at 3; unused MSBs are 0.

Optional Feature:
- Macro CSI2TX_LDL_SCHED_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT_DONE and clears on entering WAIT_DONE.
  - Reaching TIMEOUT_CYCLES sets timeout_err, which stays set until reset.
  - It also forces IDLE, clearing the grant and enable_hs_transmission, in the same way as forcetxstopmode.
- When undefined:
  - timeout_err is tied to 0, the counter is absent, and WAIT_DONE waits indefinitely.

Test Plan:
- Reset, tinit_start=1, then pkt_req=4'b0001, pkt_short=1 → pkt_grant=0001 two cycles later, enable_hs_transmission=1, short_packet=1.
- Release: tx_done=1 for 3 cycles, then hs_exit_cnt_expired pulse → enable_hs_transmission=0 one cycle after tx_done, grant clears on expiry, exactly 4 idle cycles in GAP, busy=0 afterwards.
- pkt_req=4'b1111 held for 4 packets → grants in order 0001, 0010, 0100, 1000, then 0001 again (RR wrap).
- Reconfigure mid-packet: lane_cfg_wr with lane_cfg=11 in WAIT_DONE → lane_en stays 0001 until IDLE, then becomes 1000 before the next grant.
- Abort paths: forcetxstopmode=1 in WAIT_DONE → IDLE next cycle, pkt_grant=0, RR pointer preserved; repeat with tinit_start=0 → same result plus lane_en=0.
- With CSI2TX_LDL_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, never assert tx_done → timeout_err=1 after 16 cycles in WAIT_DONE, state IDLE, flag still set after 100 more cycles.
